change_dispenser: RTL and testbench

Serial coin-frame transmitter for returning change. It accepts an 8-bit change amount in cents and splits it greedily into quarters, dimes, nickels and pennies. It emits one coin frame per coin on a single idle-high serial line. The frame format is exactly what the coinSensor decoder accepts, so the block sits on the coin-return path and can drive the coin sensor directly in loopback.

---
 rtl/change_dispenser_if.sv | 21 ++
 rtl/change_dispenser.sv | 126 ++++++++++++
 tb/tb_change_dispenser.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Request/response and serial-line bundle for the change dispenser.
// The master side issues change requests; the slave side is the dispenser.
interface change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       ready;
  logic       serialOut;
  logic [1:0] coin;
  logic [7:0] remaining;
  logic       done;

  modport master (
    output start, amount,
    input  ready, serialOut, coin, remaining, done
  );

  modport slave (
    input  start, amount,
    output ready, serialOut, coin, remaining, done
  );
endinterface

// File: rtl/change_dispenser.sv
// Splits a change amount greedily into coins and sends one idle-high coin
// frame per coin. Every output is a flop, one cycle behind the FSM state.
module change_dispenser #(
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 2
) (
  input logic              clk,
  input logic              reset,
  change_dispenser_if.slave bus
);

  localparam int          GAP_CYCLES = GAP_BITS * BIT_CYCLES;
  localparam logic [15:0] BIT_LAST   = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SELECT, SEND, GAP, DONE} state_t;

  state_t      state;
  logic [4:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic [15:0] cyc_cnt;
  logic [15:0] gap_cnt;
  logic        ready_q;
  logic        serial_q;
  logic        done_q;
  logic [1:0]  coin_q;
  logic [7:0]  rem_q;

  logic        accept;
  logic [7:0]  coin_value;
  logic [7:0]  rem_after;

  // Acceptance is gated by the registered ready so start is honoured only
  // in cycles where ready is actually visible high.
  always_comb begin
    accept     = 1'b0;
    coin_value = 8'd1;
    rem_after  = rem_q;
    accept = (state == IDLE) && ready_q && bus.start;
    case (coin_q)
      2'd3:    coin_value = 8'd25;
      2'd2:    coin_value = 8'd10;
      2'd1:    coin_value = 8'd5;
      default: coin_value = 8'd1;
    endcase
    if (gap_cnt == 16'd0) rem_after = rem_q - coin_value;
  end

  // The coin's value is taken off on the first gap cycle, which is the edge
  // that ends the last bit as seen on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      cyc_cnt   <= '0;
      gap_cnt   <= '0;
      ready_q   <= 1'b1;
      serial_q  <= 1'b1;
      done_q    <= 1'b0;
      coin_q    <= 2'd0;
      rem_q     <= 8'd0;
    end else begin
      serial_q <= (state == SEND) ? shift_reg[4] : 1'b1;
      done_q   <= (state == DONE);
      ready_q  <= (state == IDLE) && !accept;
      case (state)
        IDLE: begin
          if (accept) begin
            rem_q <= bus.amount;
            state <= (bus.amount == 8'd0) ? DONE : SELECT;
          end
        end
        SELECT: begin
          cyc_cnt <= '0;
          state   <= SEND;
          if (rem_q >= 8'd25) begin
            coin_q    <= 2'd3;
            shift_reg <= 5'b01010;
            bit_cnt   <= 3'd4;
          end else if (rem_q >= 8'd10) begin
            coin_q    <= 2'd2;
            shift_reg <= 5'b01110;
            bit_cnt   <= 3'd4;
          end else if (rem_q >= 8'd5) begin
            coin_q    <= 2'd1;
            shift_reg <= 5'b01000;
            bit_cnt   <= 3'd4;
          end else begin
            coin_q    <= 2'd0;
            shift_reg <= 5'b00100;
            bit_cnt   <= 3'd3;
          end
        end
        SEND: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == 3'd0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              bit_cnt   <= bit_cnt - 3'd1;
              shift_reg <= {shift_reg[3:0], 1'b0};
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) rem_q <= rem_q - coin_value;
          if (gap_cnt == GAP_LAST) state <= (rem_after == 8'd0) ? DONE : SELECT;
          else gap_cnt <= gap_cnt + 16'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.serialOut = serial_q;
  assign bus.coin      = coin_q;
  assign bus.remaining = rem_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench: a frame decoder on each serial line feeds received
// coins into queues that are compared against a greedy-split scoreboard.
module tb_change_dispenser;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  change_dispenser_if bus1();
  change_dispenser_if bus3();

  change_dispenser #(.BIT_CYCLES(1), .GAP_BITS(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  change_dispenser #(.BIT_CYCLES(3), .GAP_BITS(2)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_q[$];
  int rx_q0[$];
  int rx_q1[$];
  int rem_seq[$];

  bit         rx_active[2];
  bit         rx_wait[2];
  int         rx_cnt[2];
  int         rx_nb[2];
  int         rx_len[2];
  int         hold_err[2];
  logic [4:0] rx_bits[2];
  logic       rx_cur[2];
  int         low_count1    = 0;
  int         first_low_cyc = -1;
  int         done_count1   = 0;
  logic [7:0] last_rem      = 8'd0;

  // Coin-sensor model: frames start on a low bit, bits are sampled at the
  // start of each bit time and every other cycle of a bit must hold.
  always @(negedge clk) begin
    logic line;
    int   bc;
    int   code;
    for (int k = 0; k < 2; k++) begin
      line = (k == 0) ? bus1.serialOut : bus3.serialOut;
      bc   = (k == 0) ? 1 : 3;
      if (reset) begin
        rx_active[k] = 1'b0;
        rx_wait[k]   = 1'b0;
      end else if (rx_wait[k]) begin
        if (line) rx_wait[k] = 1'b0;
      end else if (!rx_active[k]) begin
        if (!line) begin
          rx_active[k] = 1'b1;
          rx_cnt[k]    = 0;
          rx_nb[k]     = 1;
          rx_len[k]    = 5;
          rx_bits[k]   = 5'b00000;
          rx_cur[k]    = 1'b0;
        end
      end else begin
        rx_cnt[k]++;
        if (rx_cnt[k] % bc == 0) begin
          rx_cur[k] = line;
          rx_bits[k][4 - rx_nb[k]] = line;
          rx_nb[k]++;
          if (rx_nb[k] == 2 && !line) rx_len[k] = 4;
          if (rx_nb[k] == rx_len[k]) begin
            code = 9;
            if (rx_len[k] == 4) begin
              if (rx_bits[k][4:1] == 4'b0010) code = 0;
            end else begin
              case (rx_bits[k])
                5'b01010: code = 3;
                5'b01110: code = 2;
                5'b01000: code = 1;
                default:  code = 9;
              endcase
            end
            if (k == 0) rx_q0.push_back(code);
            else        rx_q1.push_back(code);
            rx_active[k] = 1'b0;
            rx_wait[k]   = 1'b1;
          end
        end else if (line != rx_cur[k]) begin
          hold_err[k]++;
        end
      end
    end
    if (!reset) begin
      if (!bus1.serialOut) begin
        low_count1++;
        if (first_low_cyc < 0) first_low_cyc = cyc;
      end
      if (bus1.done) done_count1++;
    end
    if (bus1.remaining != last_rem) begin
      rem_seq.push_back(int'(bus1.remaining));
      last_rem = bus1.remaining;
    end
  end

  function automatic int coin_cents(input int code);
    case (code)
      3:       return 25;
      2:       return 10;
      1:       return 5;
      default: return 1;
    endcase
  endfunction

  // Greedy split by division; pushes expected coins and returns the total cost.
  function automatic int greedy(input int a, input int bc);
    int q, d, n, p, r;
    q = a / 25;  r = a % 25;
    d = r / 10;  r = r % 10;
    n = r / 5;   p = r % 5;
    for (int i = 0; i < q; i++) exp_q.push_back(3);
    for (int i = 0; i < d; i++) exp_q.push_back(2);
    for (int i = 0; i < n; i++) exp_q.push_back(1);
    for (int i = 0; i < p; i++) exp_q.push_back(0);
    return (q + d + n) * (1 + 5 * bc + 2 * bc) + p * (1 + 4 * bc + 2 * bc);
  endfunction

  task automatic drive(input int k, input logic s, input logic [7:0] a);
    if (k == 0) begin bus1.start = s; bus1.amount = a; end
    else        begin bus3.start = s; bus3.amount = a; end
  endtask

  function automatic logic get_done(input int k);
    return (k == 0) ? bus1.done : bus3.done;
  endfunction

  task automatic start_req(input int k, input logic [7:0] a, output int e0);
    @(negedge clk);
    drive(k, 1'b1, a);
    @(posedge clk);
    #1;
    e0 = cyc;
    drive(k, 1'b0, a);
  endtask

  task automatic wait_done(input int k, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (get_done(k)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, 1'b0, 8'd0);
    drive(1, 1'b0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus1.ready, bus1.serialOut, bus1.done, bus1.coin, bus1.remaining} !== 13'b1_1_0_00_00000000) begin
      failures++;
      $display("[TB] FAIL reset_outputs_dut1: got %b expected %b",
               {bus1.ready, bus1.serialOut, bus1.done, bus1.coin, bus1.remaining}, 13'b1_1_0_00_00000000);
    end
    checks++;
    if ({bus3.ready, bus3.serialOut, bus3.done, bus3.coin, bus3.remaining} !== 13'b1_1_0_00_00000000) begin
      failures++;
      $display("[TB] FAIL reset_outputs_dut3: got %b expected %b",
               {bus3.ready, bus3.serialOut, bus3.done, bus3.coin, bus3.remaining}, 13'b1_1_0_00_00000000);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus1.ready, bus1.serialOut, bus1.done} !== 3'b110) begin
        failures++;
        $display("[TB] FAIL idle_cycle_%0d: got %b expected 110", i, {bus1.ready, bus1.serialOut, bus1.done});
      end
    end
  endtask

  task automatic test_amount41;
    int s, e0, n, r;
    int exp_rem[$];
    exp_q.delete(); rx_q0.delete(); rem_seq.delete();
    first_low_cyc = -1;
    done_count1   = 0;
    s = greedy(41, 1);
    start_req(0, 8'd41, e0);
    wait_done(0, 200, n);
    checks++;
    if (n !== 1 + s) begin
      failures++;
      $display("[TB] FAIL done_edge_41: got %0d expected %0d (-1 = timeout)", n, 1 + s);
    end
    checks++;
    if (bus1.ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_in_done_41: got %b expected 0", bus1.ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus1.done, bus1.ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL after_done_41: got done,ready=%b expected 01", {bus1.done, bus1.ready});
    end
    checks++;
    if (first_low_cyc - e0 !== 2) begin
      failures++;
      $display("[TB] FAIL first_bit_41: got %0d edges expected 2", first_low_cyc - e0);
    end
    checks++;
    if (done_count1 !== 1) begin
      failures++;
      $display("[TB] FAIL done_pulses_41: got %0d expected 1", done_count1);
    end
    checks++;
    if (rx_q0.size() !== exp_q.size()) begin
      failures++;
      $display("[TB] FAIL frames_41_count: got %0d expected %0d", rx_q0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q0.size(); i++) begin
      checks++;
      if (rx_q0[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL frame_41_%0d: got coin %0d expected %0d", i, rx_q0[i], exp_q[i]);
      end
    end
    r = 41;
    exp_rem.push_back(r);
    foreach (exp_q[i]) begin
      r = r - coin_cents(exp_q[i]);
      exp_rem.push_back(r);
    end
    checks++;
    if (rem_seq.size() !== exp_rem.size()) begin
      failures++;
      $display("[TB] FAIL remaining_41_count: got %0d expected %0d", rem_seq.size(), exp_rem.size());
    end
    for (int i = 0; i < exp_rem.size() && i < rem_seq.size(); i++) begin
      checks++;
      if (rem_seq[i] !== exp_rem[i]) begin
        failures++;
        $display("[TB] FAIL remaining_41_%0d: got %0d expected %0d", i, rem_seq[i], exp_rem[i]);
      end
    end
  endtask

  task automatic test_zero;
    int e0, n, low_before;
    rx_q0.delete();
    low_before = low_count1;
    start_req(0, 8'd0, e0);
    wait_done(0, 10, n);
    checks++;
    if (n !== 1) begin
      failures++;
      $display("[TB] FAIL done_edge_0: got %0d expected 1 (-1 = timeout)", n);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus1.done, bus1.ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL after_done_0: got done,ready=%b expected 01", {bus1.done, bus1.ready});
    end
    checks++;
    if (low_count1 !== low_before || rx_q0.size() !== 0) begin
      failures++;
      $display("[TB] FAIL line_quiet_0: got %0d low cycles %0d frames expected 0 0",
               low_count1 - low_before, rx_q0.size());
    end
  endtask

  task automatic test_max_slow;
    int s, e0, n;
    exp_q.delete(); rx_q1.delete();
    hold_err[1] = 0;
    s = greedy(255, 3);
    start_req(1, 8'd255, e0);
    wait_done(1, 400, n);
    checks++;
    if (n !== 1 + s) begin
      failures++;
      $display("[TB] FAIL done_edge_255: got %0d expected %0d (-1 = timeout)", n, 1 + s);
    end
    checks++;
    if (hold_err[1] !== 0) begin
      failures++;
      $display("[TB] FAIL bit_hold_255: got %0d unstable cycles expected 0", hold_err[1]);
    end
    checks++;
    if (bus3.remaining !== 8'd0) begin
      failures++;
      $display("[TB] FAIL remaining_255: got %0d expected 0", bus3.remaining);
    end
    checks++;
    if (rx_q1.size() !== exp_q.size()) begin
      failures++;
      $display("[TB] FAIL frames_255_count: got %0d expected %0d", rx_q1.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q1.size(); i++) begin
      checks++;
      if (rx_q1[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL frame_255_%0d: got coin %0d expected %0d", i, rx_q1[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int s1, s2, n;
    exp_q.delete(); rx_q0.delete();
    done_count1 = 0;
    s1 = greedy(30, 1);
    s2 = greedy(7, 1);
    @(negedge clk);
    drive(0, 1'b1, 8'd30);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 8'd7);
    wait_done(0, 100, n);
    checks++;
    if (n !== 1 + s1) begin
      failures++;
      $display("[TB] FAIL done_edge_30: got %0d expected %0d (-1 = timeout)", n, 1 + s1);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus1.ready, bus1.remaining} !== {1'b1, 8'd0}) begin
      failures++;
      $display("[TB] FAIL ready_return_30: got ready=%b rem=%0d expected ready=1 rem=0", bus1.ready, bus1.remaining);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus1.ready, bus1.remaining} !== {1'b0, 8'd7}) begin
      failures++;
      $display("[TB] FAIL second_accept: got ready=%b rem=%0d expected ready=0 rem=7", bus1.ready, bus1.remaining);
    end
    drive(0, 1'b0, 8'd7);
    wait_done(0, 100, n);
    checks++;
    if (n !== 1 + s2) begin
      failures++;
      $display("[TB] FAIL done_edge_7: got %0d expected %0d (-1 = timeout)", n, 1 + s2);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_count1 !== 2) begin
      failures++;
      $display("[TB] FAIL done_pulses_b2b: got %0d expected 2", done_count1);
    end
    checks++;
    if (rx_q0.size() !== exp_q.size()) begin
      failures++;
      $display("[TB] FAIL frames_b2b_count: got %0d expected %0d", rx_q0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q0.size(); i++) begin
      checks++;
      if (rx_q0[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL frame_b2b_%0d: got coin %0d expected %0d", i, rx_q0[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int s, e0, n;
    start_req(0, 8'd10, e0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({bus1.coin, bus1.remaining} !== {2'd2, 8'd10}) begin
      failures++;
      $display("[TB] FAIL dime_in_flight: got coin=%0d rem=%0d expected coin=2 rem=10", bus1.coin, bus1.remaining);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus1.ready, bus1.serialOut, bus1.done, bus1.coin, bus1.remaining} !== 13'b1_1_0_00_00000000) begin
      failures++;
      $display("[TB] FAIL async_reset: got %b expected %b",
               {bus1.ready, bus1.serialOut, bus1.done, bus1.coin, bus1.remaining}, 13'b1_1_0_00_00000000);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); rx_q0.delete();
    s = greedy(5, 1);
    start_req(0, 8'd5, e0);
    wait_done(0, 50, n);
    checks++;
    if (n !== 1 + s) begin
      failures++;
      $display("[TB] FAIL done_edge_5: got %0d expected %0d (-1 = timeout)", n, 1 + s);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rx_q0.size() !== 1 || (rx_q0.size() == 1 && rx_q0[0] !== exp_q[0])) begin
      failures++;
      $display("[TB] FAIL nickel_after_reset: got %0d frames first=%0d expected 1 frame coin %0d",
               rx_q0.size(), (rx_q0.size() > 0) ? rx_q0[0] : -1, exp_q[0]);
    end
  endtask

  task automatic test_loopback;
    int amounts[5] = '{1, 5, 10, 25, 66};
    int s, e0, n;
    exp_q.delete(); rx_q0.delete();
    foreach (amounts[j]) begin
      s = greedy(amounts[j], 1);
      start_req(0, 8'(amounts[j]), e0);
      wait_done(0, 200, n);
      checks++;
      if (n !== 1 + s) begin
        failures++;
        $display("[TB] FAIL done_edge_loop_%0d: got %0d expected %0d (-1 = timeout)", amounts[j], n, 1 + s);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (rx_q0.size() !== exp_q.size()) begin
      failures++;
      $display("[TB] FAIL frames_loop_count: got %0d expected %0d", rx_q0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q0.size(); i++) begin
      checks++;
      if (rx_q0[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL frame_loop_%0d: got coin %0d expected %0d", i, rx_q0[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus1.start = 1'b0; bus1.amount = 8'd0;
    bus3.start = 1'b0; bus3.amount = 8'd0;
    test_reset();
    test_amount41();
    test_zero();
    test_max_slow();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
